// File: rtl/gcd_stein_unit.sv
// gcd_stein_unit: binary (Stein) GCD engine.
// One operand pair is in flight at a time. Each REDUCE step is either a shift
// or a subtract-and-shift. The result and the number of REDUCE steps are held
// on the output channel until the consumer takes them.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready is high only in IDLE, and out_valid is high only in OUT.
// out_gcd and out_cycles stay stable while out_valid=1 and out_ready=0.
module gcd_stein_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(2*WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_cycles,
    output logic [1:0]       dbg_state_o
);

    localparam int K_W = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [K_W-1:0]   K_ONE   = K_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    // Both subtractions are formed, but only the one where the larger operand
    // is the minuend is used, so neither can wrap when it is selected.
    logic [WIDTH-1:0] diff_ab, diff_ba;
    assign diff_ab = a_q - b_q;
    assign diff_ba = b_q - a_q;

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state and datapath update: accept, one reduction step, or hand off.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        cyc_d   = cyc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if ((in_a == '0) || (in_b == '0)) begin
                        // gcd(x,0)=x and gcd(0,0)=0, no reduction needed
                        gcd_d   = in_a | in_b;
                        cyc_d   = '0;
                        state_d = ST_OUT;
                    end else begin
                        a_d     = in_a;
                        b_d     = in_b;
                        k_d     = '0;
                        cnt_d   = '0;
                        state_d = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (a_q == b_q) begin
                    // restore the common power of two removed earlier
                    gcd_d   = a_q << k_q;
                    cyc_d   = cnt_q + CNT_ONE;
                    state_d = ST_OUT;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_ONE;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    // odd minus odd is even, so the shift drops no information
                    a_d = diff_ab >> 1;
                end else begin
                    b_d = diff_ba >> 1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags, result outputs and the exposed state are all decoded
    // from registers.
    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        out_valid   = (state_q == ST_OUT);
        out_gcd     = gcd_q;
        out_cycles  = cyc_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_gcd_stein_unit.sv
// Testbench for gcd_stein_unit. It runs directed cases, then backpressure and
// reset-abort cases, then random pairs checked against a Euclid reference.
module tb_gcd_stein_unit;

    localparam int W  = 32;
    localparam int CW = $clog2(2*W+1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_gcd;
    logic [CW-1:0] out_cycles;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // clock
    always #5 clk = ~clk;

    gcd_stein_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gcd    (out_gcd),
        .out_cycles (out_cycles),
        .dbg_state_o(dbg_state)
    );

    // reference model: Euclid's algorithm on plain integers
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs are driven and outputs are sampled at negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver: wait for in_ready (bounded), present one pair for one edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        exp_q.push_back(ref_gcd(a, b));
        tick();
        in_valid = 1'b0;
        // later changes to the operands must have no effect
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    // count edges after the acceptance edge until out_valid (bounded)
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            tick();
            lat++;
        end
        check("out_valid_seen", out_valid, 1'b1);
    endtask

    // scoreboard + consumer: check the result, stall, then complete the handshake
    task automatic recv(input int stall, output logic [CW-1:0] cyc);
        logic [W-1:0] g;
        logic [W-1:0] e;
        g   = out_gcd;
        cyc = out_cycles;
        e   = exp_q.pop_front();
        check("gcd", g, e);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            tick();
            check("hold_valid", out_valid, 1'b1);
            check("hold_gcd", out_gcd, g);
            check("hold_cycles", out_cycles, cyc);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        check("hs_in_ready_low", in_ready, 1'b0);
        tick();
        out_ready = 1'b0;
        check("post_hs_in_ready", in_ready, 1'b1);
        check("post_hs_out_valid", out_valid, 1'b0);
    endtask

    task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                            output logic [CW-1:0] cyc, output int lat);
        send(a, b);
        wait_out(lat);
        recv(stall, cyc);
    endtask

    logic [W-1:0]  za [3] = '{32'd0, 32'd0, 32'd9};
    logic [W-1:0]  zb [3] = '{32'd0, 32'd7, 32'd0};
    logic [W-1:0]  da [4] = '{32'd5, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF};
    logic [W-1:0]  db [4] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1};
    int            dc [4] = '{1, 1, 32, 32};

    initial begin
        logic [CW-1:0] cyc;
        logic [W-1:0]  a, b, m, g;
        int            lat;
        bit            seen;

        // reset
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_gcd", out_gcd, 32'd0);
        check("rst_out_cycles", out_cycles, 7'd0);

        // basic example
        run_pair(32'd48, 32'd18, 0, cyc, lat);
        check("ex_cycles", cyc, 7'd6);
        check("ex_latency", lat, 6);

        // zero operands: one edge, zero steps
        for (int i = 0; i < 3; i++) begin
            run_pair(za[i], zb[i], 1, cyc, lat);
            check("zero_cycles", cyc, 7'd0);
            check("zero_latency", lat, 0);
        end

        // boundary pairs
        for (int i = 0; i < 4; i++) begin
            run_pair(da[i], db[i], 0, cyc, lat);
            check("dir_cycles", cyc, dc[i]);
            check("dir_latency", lat, dc[i]);
        end

        // backpressure with a competing pair offered during the stall
        send(32'd12, 32'd8);
        wait_out(lat);
        g = exp_q.pop_front();
        check("bp_gcd", out_gcd, g);
        check("bp_gcd_value", out_gcd, 32'd4);
        in_valid = 1'b1;
        in_a     = 32'd7;
        in_b     = 32'd3;
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b0;
            tick();
            check("bp_valid", out_valid, 1'b1);
            check("bp_hold_gcd", out_gcd, 32'd4);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_back_idle", in_ready, 1'b1);
        exp_q.push_back(ref_gcd(32'd7, 32'd3));
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        recv(0, cyc);
        check("bp_next_cycles", cyc, 7'd4);
        check("bp_next_latency", lat, 4);

        // reset during REDUCE discards the pair
        send(32'd1, 32'h8000_0000);
        void'(exp_q.pop_back());
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_gcd", out_gcd, 32'd0);
        check("abort_out_cycles", out_cycles, 7'd0);
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_never_valid", seen, 1'b0);
        run_pair(32'd21, 32'd14, 2, cyc, lat);
        check("after_abort_cycles", cyc, 7'd3);

        // random pairs with random stalls
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0: begin
                    a = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
                    b = (a == 0 && $urandom_range(0, 1) == 0) ? $urandom : 32'd0;
                end
                1, 2, 3: begin
                    m = $urandom_range(1, 4096);
                    a = $urandom_range(1, 1 << 19) * m;
                    b = $urandom_range(1, 1 << 19) * m;
                end
                default: begin
                    a = $urandom;
                    b = $urandom;
                    if (a == 0) a = 32'd1;
                    if (b == 0) b = 32'd1;
                end
            endcase
            run_pair(a, b, $urandom_range(0, 3), cyc, lat);
            check("rand_cycle_bound", (cyc <= 7'd64), 1'b1);
            if (a == 0 || b == 0) begin
                check("rand_zero_cycles", cyc, 7'd0);
                check("rand_zero_latency", lat, 0);
            end else begin
                check("rand_latency", lat, cyc);
            end
        end

        check("queue_empty", exp_q.size(), 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
